// File: rtl/pipe_stall_flush_ctrl.sv
// Purpose: pipeline hazard controller; merges stage stall requests into a thermometer stall vector and sequences flushes.
// Latency: stall/flush_ack combinational; flush/flush_busy/new_pc follow 1 cycle after acceptance, held FLUSH_CYCLES cycles.
// Backpressure: flush_req is not queued; the requester holds it until flush_ack. Optional perf counters under PIPE_CTRL_PERF_EN.
module pipe_stall_flush_ctrl #(
    parameter int NUM_STAGES    = 6,
    parameter int ADDR_W        = 32,
    parameter int FLUSH_CYCLES  = 1,
    parameter int STALL_TIMEOUT = 64,
    parameter int CNT_W         = 16
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic [NUM_STAGES-1:0] stallreq,
    input  logic                  flush_req,
    input  logic [ADDR_W-1:0]     flush_pc,
    output logic [NUM_STAGES-1:0] stall,
    output logic                  flush,
    output logic [ADDR_W-1:0]     new_pc,
    output logic                  flush_ack,
    output logic                  flush_busy,
    output logic                  stall_timeout,
    output logic [31:0]           stall_cycles,
    output logic [31:0]           flush_count
);

    localparam logic [0:0]       ST_RUN     = 1'b0;
    localparam logic [0:0]       ST_FLUSH   = 1'b1;
    localparam logic [3:0]       FLUSH_LAST = 4'(FLUSH_CYCLES - 1);
    localparam logic [CNT_W-1:0] TIMEOUT_V  = CNT_W'(STALL_TIMEOUT);
    localparam logic [CNT_W-1:0] CNT_MAX    = '1;
    localparam bit               WD_EN      = (STALL_TIMEOUT != 0);

    logic [0:0]            state_q, state_d;
    logic [3:0]            flush_cnt_q, flush_cnt_d;
    logic [ADDR_W-1:0]     new_pc_q, new_pc_d;
    logic [CNT_W-1:0]      scnt_q, scnt_d, scnt_inc;
    logic                  stall_timeout_q, stall_timeout_d;
    logic [NUM_STAGES-1:0] stall_raw;
    logic                  hit;
    logic                  accept;
    logic                  stall_any;

    // Thermometer: every stage at or below the highest requester stalls
    always_comb begin
        stall_raw = '0;
        hit       = 1'b0;
        for (int k = NUM_STAGES - 1; k >= 0; k--) begin
            hit          = hit | stallreq[k];
            stall_raw[k] = hit;
        end
    end

    // Request acceptance and stall gating; a flush in progress or being accepted preempts any stall
    always_comb begin
        accept    = !rst && (state_q == ST_RUN) && flush_req;
        flush_ack = accept;
        stall     = (!rst && (state_q == ST_RUN) && !flush_req) ? stall_raw : '0;
        stall_any = |stall;
    end

    // Flush sequencer next state: latch redirect on acceptance, count down the flush window
    always_comb begin
        state_d     = state_q;
        flush_cnt_d = flush_cnt_q;
        new_pc_d    = new_pc_q;
        if (state_q == ST_RUN) begin
            if (flush_req) begin
                state_d     = ST_FLUSH;
                flush_cnt_d = FLUSH_LAST;
                new_pc_d    = flush_pc;
            end
        end else begin
            if (flush_cnt_q == 4'd0) begin
                state_d = ST_RUN;
            end else begin
                flush_cnt_d = flush_cnt_q - 4'd1;
            end
        end
    end

    // Watchdog next state: saturating run-length of stalled cycles, sticky flag cleared by a flush acceptance
    always_comb begin
        scnt_inc        = (scnt_q == CNT_MAX) ? scnt_q : scnt_q + 1'b1;
        scnt_d          = stall_any ? scnt_inc : '0;
        stall_timeout_d = stall_timeout_q;
        if (WD_EN && stall_any && (scnt_inc == TIMEOUT_V)) begin
            stall_timeout_d = 1'b1;
        end
        if (accept) begin
            stall_timeout_d = 1'b0;
        end
    end

    // Control state registers
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q         <= ST_RUN;
            flush_cnt_q     <= 4'd0;
            new_pc_q        <= '0;
            scnt_q          <= '0;
            stall_timeout_q <= 1'b0;
        end else begin
            state_q         <= state_d;
            flush_cnt_q     <= flush_cnt_d;
            new_pc_q        <= new_pc_d;
            scnt_q          <= scnt_d;
            stall_timeout_q <= stall_timeout_d;
        end
    end

    assign flush         = (state_q == ST_FLUSH);
    assign flush_busy    = (state_q == ST_FLUSH);
    assign new_pc        = new_pc_q;
    assign stall_timeout = stall_timeout_q;

`ifdef PIPE_CTRL_PERF_EN
    logic [31:0] stall_cycles_q, stall_cycles_d;
    logic [31:0] flush_count_q, flush_count_d;

    // Perf counter next values: wrapping counts of stalled cycles and accepted flushes
    always_comb begin
        stall_cycles_d = stall_any ? stall_cycles_q + 32'd1 : stall_cycles_q;
        flush_count_d  = accept ? flush_count_q + 32'd1 : flush_count_q;
    end

    // Perf counter registers
    always_ff @(posedge clk) begin
        if (rst) begin
            stall_cycles_q <= 32'd0;
            flush_count_q  <= 32'd0;
        end else begin
            stall_cycles_q <= stall_cycles_d;
            flush_count_q  <= flush_count_d;
        end
    end

    assign stall_cycles = stall_cycles_q;
    assign flush_count  = flush_count_q;
`else
    assign stall_cycles = 32'd0;
    assign flush_count  = 32'd0;
`endif

endmodule

// File: tb/tb_pipe_stall_flush_ctrl.sv
// Purpose: directed self-checking bench for pipe_stall_flush_ctrl (FLUSH_CYCLES=3 and FLUSH_CYCLES=1 instances).
// Latency: inputs driven on the falling edge, outputs sampled 1 time unit later.
// Backpressure: flush_req held/pulsed explicitly by the directed steps.
module tb_pipe_stall_flush_ctrl;

    logic        clk;
    logic        rst;
    logic [5:0]  stallreq;
    logic        flush_req;
    logic        flush_req1;
    logic [31:0] flush_pc;

    logic [5:0]  stall, stall1;
    logic        flush, flush1;
    logic [31:0] new_pc, new_pc1;
    logic        flush_ack, flush_ack1;
    logic        flush_busy, flush_busy1;
    logic        stall_timeout, stall_timeout1;
    logic [31:0] stall_cycles, stall_cycles1;
    logic [31:0] flush_count, flush_count1;

    int total = 0;
    int bad   = 0;

    pipe_stall_flush_ctrl #(
        .NUM_STAGES(6), .ADDR_W(32), .FLUSH_CYCLES(3), .STALL_TIMEOUT(64), .CNT_W(16)
    ) dut (
        .clk(clk), .rst(rst), .stallreq(stallreq), .flush_req(flush_req), .flush_pc(flush_pc),
        .stall(stall), .flush(flush), .new_pc(new_pc), .flush_ack(flush_ack),
        .flush_busy(flush_busy), .stall_timeout(stall_timeout),
        .stall_cycles(stall_cycles), .flush_count(flush_count)
    );

    pipe_stall_flush_ctrl #(
        .NUM_STAGES(6), .ADDR_W(32), .FLUSH_CYCLES(1), .STALL_TIMEOUT(64), .CNT_W(16)
    ) dut1 (
        .clk(clk), .rst(rst), .stallreq(stallreq), .flush_req(flush_req1), .flush_pc(flush_pc),
        .stall(stall1), .flush(flush1), .new_pc(new_pc1), .flush_ack(flush_ack1),
        .flush_busy(flush_busy1), .stall_timeout(stall_timeout1),
        .stall_cycles(stall_cycles1), .flush_count(flush_count1)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        total++;
        assert (got === exp) else begin
            bad++;
            $error("FAIL %s observed=%0h expected=%0h", tag, got, exp);
        end
    endtask

    // Expected perf counter value for the current build
    function automatic logic [31:0] pexp(input logic [31:0] v);
`ifdef PIPE_CTRL_PERF_EN
        return v;
`else
        return 32'd0 & v;
`endif
    endfunction

    task automatic step();
        @(negedge clk);
    endtask

    logic [5:0] sweep_in  [6];
    logic [5:0] sweep_exp [6];

    initial begin
        sweep_in[0] = 6'b000100; sweep_exp[0] = 6'b000111;
        sweep_in[1] = 6'b001000; sweep_exp[1] = 6'b001111;
        sweep_in[2] = 6'b001100; sweep_exp[2] = 6'b001111;
        sweep_in[3] = 6'b100000; sweep_exp[3] = 6'b111111;
        sweep_in[4] = 6'b000001; sweep_exp[4] = 6'b000001;
        sweep_in[5] = 6'b000000; sweep_exp[5] = 6'b000000;

        // Reset with every request active
        rst = 1'b1; stallreq = 6'b111111; flush_req = 1'b1; flush_req1 = 1'b1; flush_pc = 32'h1234_5678;
        for (int i = 0; i < 2; i++) begin
            step(); #1;
            chk("rst_stall", 64'(stall), 64'h0);
            chk("rst_flush", 64'(flush), 64'h0);
            chk("rst_ack", 64'(flush_ack), 64'h0);
        end

        // First cycle after release
        step();
        rst = 1'b0; stallreq = 6'b000000; flush_req = 1'b0; flush_req1 = 1'b0;
        #1;
        chk("rel_flush", 64'(flush), 64'h0);
        chk("rel_busy", 64'(flush_busy), 64'h0);
        chk("rel_new_pc", 64'(new_pc), 64'h0);
        chk("rel_timeout", 64'(stall_timeout), 64'h0);
        chk("rel_scyc", 64'(stall_cycles), 64'h0);
        chk("rel_fcnt", 64'(flush_count), 64'h0);

        // Thermometer sweep
        for (int i = 0; i < 6; i++) begin
            step(); stallreq = sweep_in[i]; #1;
            chk("therm", 64'(stall), 64'(sweep_exp[i]));
        end
        chk("scyc_after_sweep", 64'(stall_cycles), 64'(pexp(32'd5)));

        // 3-cycle flush with a mid-flush re-pulse
        step(); stallreq = 6'b001000; flush_req = 1'b1; flush_pc = 32'hBFC0_0380; #1;
        chk("acc_ack", 64'(flush_ack), 64'h1);
        chk("acc_stall", 64'(stall), 64'h0);
        chk("acc_flush", 64'(flush), 64'h0);
        step(); flush_req = 1'b0; #1;
        chk("f1_flush", 64'(flush), 64'h1);
        chk("f1_busy", 64'(flush_busy), 64'h1);
        chk("f1_pc", 64'(new_pc), 64'hBFC0_0380);
        chk("f1_stall", 64'(stall), 64'h0);
        step(); flush_req = 1'b1; flush_pc = 32'h0000_1111; #1;
        chk("f2_flush", 64'(flush), 64'h1);
        chk("f2_ack", 64'(flush_ack), 64'h0);
        chk("f2_pc", 64'(new_pc), 64'hBFC0_0380);
        step(); flush_req = 1'b0; #1;
        chk("f3_flush", 64'(flush), 64'h1);
        chk("f3_pc", 64'(new_pc), 64'hBFC0_0380);
        step(); #1;
        chk("post_flush", 64'(flush), 64'h0);
        chk("post_busy", 64'(flush_busy), 64'h0);
        chk("post_stall", 64'(stall), 64'b001111);
        chk("post_pc_hold", 64'(new_pc), 64'hBFC0_0380);
        chk("post_fcnt", 64'(flush_count), 64'(pexp(32'd1)));

        // Continuously held flush_req on the FLUSH_CYCLES=1 instance
        step(); stallreq = 6'b000000; flush_req1 = 1'b1; #1;
        for (int i = 0; i < 6; i++) begin
            chk("held_flush", 64'(flush1), 64'(i % 2));
            chk("held_ack", 64'(flush_ack1), 64'((i + 1) % 2));
            step(); #1;
        end
        flush_req1 = 1'b0;

        // Watchdog: 64th consecutive stalled edge raises the flag
        step(); stallreq = 6'b000100; #1;
        chk("wd_start", 64'(stall_timeout), 64'h0);
        repeat (63) step();
        #1;
        chk("wd_63", 64'(stall_timeout), 64'h0);
        step(); #1;
        chk("wd_64", 64'(stall_timeout), 64'h1);
        step(); stallreq = 6'b000000; #1;
        step(); step(); #1;
        chk("wd_sticky", 64'(stall_timeout), 64'h1);
        flush_req = 1'b1; flush_pc = 32'h8000_0000; #1;
        chk("wd_clr_ack", 64'(flush_ack), 64'h1);
        step(); flush_req = 1'b0; #1;
        chk("wd_cleared", 64'(stall_timeout), 64'h0);
        chk("wd_fcnt", 64'(flush_count), 64'(pexp(32'd2)));
        repeat (3) step();

        // Reset on the 2nd cycle of a 3-cycle flush
        step(); stallreq = 6'b000010; flush_req = 1'b1; flush_pc = 32'h8000_0180; #1;
        chk("mr_ack", 64'(flush_ack), 64'h1);
        step(); flush_req = 1'b0; #1;
        chk("mr_f1", 64'(flush), 64'h1);
        chk("mr_pc", 64'(new_pc), 64'h8000_0180);
        step(); rst = 1'b1; #1;
        chk("mr_f2", 64'(flush), 64'h1);
        chk("mr_rst_stall", 64'(stall), 64'h0);
        step(); rst = 1'b0; #1;
        chk("mr_flush", 64'(flush), 64'h0);
        chk("mr_busy", 64'(flush_busy), 64'h0);
        chk("mr_stall", 64'(stall), 64'b000011);
        chk("mr_new_pc", 64'(new_pc), 64'h0);
        chk("mr_fcnt", 64'(flush_count), 64'h0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
